// File: rtl/nn_inference_engine.sv
// nn_inference_engine
// Computes one dense-layer score per class over a 28x28 binary canvas
// without a multiplier. A set pixel adds its signed weight to the score and
// a clear pixel adds nothing. The block keeps the running maximum and holds
// the winning class until reset.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   en              : clock enable; when low all state holds and rd_en is 0
//   start           : level request to begin, sampled only in IDLE
//   rd_en           : read strobe to the canvas RAM and the weight ROM
//   pixel_addr      : canvas address
//   pixel_data      : canvas bit, returned one cycle after the address
//   weight_addr     : class*N_PIXELS + pixel
//   weight_data     : signed weight, returned one cycle after the address
//   busy            : high in RUN/FLUSH/COMPARE
//   done            : high in DONE; only reset clears it
//   predicted_digit : argmax class
//   max_score       : winning score, signed
module nn_inference_engine #(
  parameter int N_PIXELS   = 784,
  parameter int N_CLASSES  = 10,
  parameter int W_WIDTH    = 8,
  parameter int ACC_WIDTH  = 18,
  parameter int PIX_ADDR_W = 10,
  parameter int W_ADDR_W   = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        start,
  output logic                        rd_en,
  output logic [PIX_ADDR_W-1:0]       pixel_addr,
  input  logic                        pixel_data,
  output logic [W_ADDR_W-1:0]         weight_addr,
  input  logic signed [W_WIDTH-1:0]   weight_data,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  predicted_digit,
  output logic signed [ACC_WIDTH-1:0] max_score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]                  class_idx;
  logic [PIX_ADDR_W-1:0]       pixel;
  logic [W_ADDR_W-1:0]         w_base;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic signed [ACC_WIDTH-1:0] max_q;
  logic [3:0]                  argmax;
  logic                        last_pixel;
  logic                        last_class;
  logic                        take_max;

  // Sign-extend the weight. A clear pixel contributes zero, so no multiplier
  // is needed.
  always_comb begin
    acc_sum    = acc + (pixel_data ?
                 {{(ACC_WIDTH-W_WIDTH){weight_data[W_WIDTH-1]}}, weight_data} :
                 {ACC_WIDTH{1'b0}});
    last_pixel = (pixel == PIX_ADDR_W'(N_PIXELS-1));
    last_class = (class_idx == 4'(N_CLASSES-1));
    // The comparison is strict, so on a tie the lowest class index wins.
    take_max   = (class_idx == 4'd0) || (acc > max_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_RUN;
      S_RUN:     if (last_pixel) state_next = S_FLUSH;
      S_FLUSH:   state_next = S_COMPARE;
      S_COMPARE: state_next = last_class ? S_DONE : S_RUN;
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Memory data lags the issued address by one cycle. Each RUN cycle with
  // pixel>0 folds in the previous pixel, and FLUSH folds in the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      class_idx <= '0;
      pixel     <= '0;
      w_base    <= '0;
      acc       <= '0;
      max_q     <= '0;
      argmax    <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            class_idx <= '0;
            pixel     <= '0;
            w_base    <= '0;
            acc       <= '0;
          end
        end
        S_RUN: begin
          if (pixel != '0) acc <= acc_sum;
          if (!last_pixel) pixel <= pixel + PIX_ADDR_W'(1);
        end
        S_FLUSH: begin
          acc <= acc_sum;
        end
        S_COMPARE: begin
          if (take_max) begin
            max_q  <= acc;
            argmax <= class_idx;
          end
          if (!last_class) begin
            class_idx <= class_idx + 4'd1;
            pixel     <= '0;
            acc       <= '0;
            w_base    <= w_base + W_ADDR_W'(N_PIXELS);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_en           = en && (state == S_RUN);
    pixel_addr      = pixel;
    weight_addr     = w_base + W_ADDR_W'(pixel);
    busy            = (state == S_RUN) || (state == S_FLUSH) || (state == S_COMPARE);
    done            = (state == S_DONE);
    predicted_digit = argmax;
    max_score       = max_q;
  end

endmodule

// File: tb/tb_nn_inference_engine.sv
module tb_nn_inference_engine;

  localparam int NP = 784;
  localparam int NC = 10;
  localparam int RUN_EDGES = NC * (NP + 2);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b1;
  logic               start = 1'b0;
  logic               rd_en;
  logic [9:0]         pixel_addr;
  logic               pixel_data = 1'b0;
  logic [12:0]        weight_addr;
  logic signed [7:0]  weight_data = '0;
  logic               busy;
  logic               done;
  logic [3:0]         predicted_digit;
  logic signed [17:0] max_score;

  nn_inference_engine #(
    .N_PIXELS(NP), .N_CLASSES(NC), .W_WIDTH(8), .ACC_WIDTH(18),
    .PIX_ADDR_W(10), .W_ADDR_W(13)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .rd_en(rd_en),
    .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .busy(busy), .done(done), .predicted_digit(predicted_digit),
    .max_score(max_score)
  );

  always #5 clk = ~clk;

  // Canvas RAM and weight ROM models: 1-cycle read latency, hold when rd_en=0.
  logic              cnv  [0:NP-1];
  logic signed [7:0] wrom [0:NP*NC-1];

  always @(posedge clk) begin
    if (rd_en) begin
      pixel_data  <= cnv[int'(pixel_addr)];
      weight_data <= wrom[int'(weight_addr)];
    end
  end

  typedef struct {
    logic [3:0] digit;
    int         score;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int p = 0; p < NP; p++) cnv[p] = 1'b0;
    for (int i = 0; i < NP*NC; i++) wrom[i] = '0;
  endtask

  // Reference argmax over the current memory contents. It is pushed when a
  // run is started.
  task automatic push_expected();
    exp_t e;
    int best = 0;
    logic [3:0] bd = '0;
    for (int c = 0; c < NC; c++) begin
      int s = 0;
      for (int p = 0; p < NP; p++)
        if (cnv[p]) s += int'(wrom[c*NP + p]);
      if (c == 0 || s > best) begin
        best = s;
        bd = c[3:0];
      end
    end
    e.digit = bd;
    e.score = best;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check({tag, "_done"}, {31'b0, done}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  // Starts a run and waits for done (bounded). gate_at>0 drops en for 100
  // edges after that edge. abort_at>0 applies reset after that edge.
  task automatic run_once(input string tag, input int gate_at,
                          input int abort_at, input int exp_edges);
    int n = 0;
    int overlap = 0;
    int gap_bad = 0;
    exp_t e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (n < exp_edges + 500) begin
      @(posedge clk); n++; #1;
      if (busy && done) overlap++;
      if (!en && rd_en) gap_bad++;
      if (gate_at > 0 && n == gate_at) en = 1'b0;
      if (gate_at > 0 && n == gate_at + 100) en = 1'b1;
      if (abort_at > 0 && n == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check({tag, "_abort_busy"},  {31'b0, busy}, 0);
        check({tag, "_abort_done"},  {31'b0, done}, 0);
        check({tag, "_abort_digit"}, {28'b0, predicted_digit}, 0);
        check({tag, "_abort_score"}, $signed(max_score), 0);
        return;
      end
      if (done) break;
    end
    check({tag, "_done_edge"}, n, exp_edges);
    check({tag, "_no_overlap"}, overlap, 0);
    if (gate_at > 0) check({tag, "_rd_en_gap"}, gap_bad, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({tag, "_digit"}, {28'b0, predicted_digit}, {28'b0, e.digit});
      check({tag, "_score"}, $signed(max_score), e.score);
    end
  endtask

  initial begin
    clear_mem();
    // Reset state.
    @(posedge clk); #1;
    do_reset("rst");
    check("rst_digit", {28'b0, predicted_digit}, 0);
    check("rst_score", $signed(max_score), 0);
    check("rst_rd_en", {31'b0, rd_en}, 0);
    check("rst_paddr", {22'b0, pixel_addr}, 0);
    check("rst_waddr", {19'b0, weight_addr}, 0);

    // All-zero canvas with random weights: the tie rule gives class 0.
    for (int i = 0; i < NP*NC; i++) wrom[i] = 8'($urandom_range(0, 255));
    push_expected();
    check("zero_model_digit", {28'b0, sb[0].digit}, 0);
    run_once("zero", 0, 0, RUN_EDGES);
    do_reset("r1");

    // Single class preference: class 7 should win with 100.
    clear_mem();
    for (int p = 0; p < 100; p++) begin
      cnv[p] = 1'b1;
      wrom[7*NP + p] = 8'sd1;
    end
    push_expected();
    run_once("single", 0, 0, RUN_EDGES);

    // Start while in DONE: it is ignored and the outputs hold.
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    check("dstart_done",  {31'b0, done}, 1);
    check("dstart_busy",  {31'b0, busy}, 0);
    check("dstart_rd_en", {31'b0, rd_en}, 0);
    check("dstart_digit", {28'b0, predicted_digit}, 7);
    check("dstart_score", $signed(max_score), 100);
    do_reset("r2");

    // Tie between classes 3 and 5: the lower index wins.
    clear_mem();
    for (int p = 0; p < 50; p++) begin
      cnv[p] = 1'b1;
      wrom[3*NP + p] = 8'sd1;
      wrom[5*NP + p] = 8'sd1;
    end
    push_expected();
    run_once("tie", 0, 0, RUN_EDGES);
    do_reset("r3");

    // All weights are -1 except class 9, which is 0.
    clear_mem();
    for (int p = 0; p < NP; p += 3) cnv[p] = 1'b1;
    for (int c = 0; c < 9; c++)
      for (int p = 0; p < NP; p++) wrom[c*NP + p] = -8'sd1;
    push_expected();
    run_once("neg1", 0, 0, RUN_EDGES);
    do_reset("r4");

    // All scores negative: class c uses weight -(10-c) on 10 set pixels.
    clear_mem();
    for (int p = 200; p < 210; p++) cnv[p] = 1'b1;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++) wrom[c*NP + p] = 8'(c - 10);
    push_expected();
    check("neg2_model_score", sb[0].score, -10);
    run_once("neg2", 0, 0, RUN_EDGES);
    do_reset("r5");

    // Random data, first ungated and then with en dropped during class 4 RUN.
    for (int p = 0; p < NP; p++) cnv[p] = 1'($urandom_range(0, 1));
    for (int i = 0; i < NP*NC; i++) wrom[i] = 8'($urandom_range(0, 255));
    push_expected();
    run_once("rand", 0, 0, RUN_EDGES);
    do_reset("r6");
    push_expected();
    run_once("gated", 4*(NP+2) + 100, 0, RUN_EDGES + 100);
    do_reset("r7");

    // Reset during the run, then a clean restart.
    run_once("abort", 0, 3000, RUN_EDGES);
    push_expected();
    run_once("restart", 0, 0, RUN_EDGES);
    do_reset("r8");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_inference_engine.md
# nn_inference_engine

Neural-network slave that answers the master controller's start/enable/reset handshake. On start it streams the 28x28 binary canvas and a signed weight ROM through a single multiply-free accumulator, computing one dense-layer score per class. It tracks the running maximum and presents the winning class as `predicted_digit`, with a level `done`. It sits between the canvas memory written by the painter and the master controller, which samples `predicted_digit` while `done` is high.

## Interface

- `N_PIXELS`, 784, canvas pixels per inference
- `N_CLASSES`, 10, output classes (max 16)
- `W_WIDTH`, 8, signed weight width
- `ACC_WIDTH`, 18, signed accumulator/score width
- `PIX_ADDR_W`, 10, canvas address width
- `W_ADDR_W`, 13, weight ROM address width

Ports:

- `clk`  in  1  clock; reset reset, synchronous, active-high; clock clk
- `reset`  in  1  synchronous active-high reset (driven by controller `reset_neural_network`)
- `en`  in  1  clock enable; when low, all state and outputs hold
- `start`  in  1  begin inference; level, sampled only in IDLE
- `rd_en`  out  1  read enable to canvas RAM and weight ROM; both memories hold their output while low
- `pixel_addr`  out  PIX_ADDR_W  canvas address
- `pixel_data`  in  1  canvas bit, valid 1 cycle after `pixel_addr` is presented with `rd_en`=1
- `weight_addr`  out  W_ADDR_W  equals class*N_PIXELS + pixel
- `weight_data`  in  W_WIDTH  signed weight, same latency as `pixel_data`
- `busy`  out  1  high in RUN/FLUSH/COMPARE
- `done`  out  1  high in DONE; held until reset
- `predicted_digit`  out  4  argmax class; valid while `done`=1
- `max_score`  out  ACC_WIDTH  winning score, signed

## Operation

- States: IDLE, RUN, FLUSH, COMPARE, DONE.
- IDLE: if `en`&&`start`, then:
  - class=0, pixel=0, acc=0;
  - go to RUN.
- RUN: `rd_en`=1 and issue address for (class, pixel), one pixel per cycle.
  - Every RUN cycle with pixel>0 accumulates the data returned for the previous address.
  - After pixel N_PIXELS-1 is issued, go to FLUSH.
- FLUSH: `rd_en`=0; accumulate the last returned pair; go to COMPARE.
- COMPARE:
  - If class==0 or acc > current max (signed, strict), load max=acc and argmax=class.
  - If class==N_CLASSES-1, go to DONE.
  - Otherwise: class++, pixel=0, acc=0, go to RUN.
- DONE: `done`=1. `predicted_digit`=argmax and `max_score`=max are held. `start` is ignored. Only `reset` leaves DONE.
- Accumulate rule: acc += `pixel_data` ? sign-extended `weight_data` : 0.
  - Two's-complement wrap at ACC_WIDTH, no saturation.
  - Defaults cannot overflow: 784*128 < 2^17.
- Ties: the lowest class index wins, as a consequence of the strict `>`.
- `en` low: the FSM, counters, acc, max and all outputs freeze, and `rd_en` drops to 0.
  - Memory outputs therefore stay aligned with the frozen pipeline.
  - Resuming continues exactly where the block stopped.
- Reset mid-operation: abort immediately to IDLE; no partial result is kept.

## Timing

- Reset values: state=IDLE, `done`=0, `busy`=0, `predicted_digit`=0, `max_score`=0, `pixel_addr`=0, `weight_addr`=0, `rd_en`=0, internal acc/max/class/pixel=0.
- Read latency is 1 cycle: data for the address issued at edge t is used at edge t+1.
- Per class: N_PIXELS (RUN) + 1 (FLUSH) + 1 (COMPARE) = 786 enabled cycles.
- `done` rises N_CLASSES*(N_PIXELS+2) = 7860 enabled edges after the edge that samples `start`.
- Cycles with `en`=0 add latency 1:1.
- `busy` and `done` are never high together.
- `done` deasserts on the first edge with `reset`=1.
- `predicted_digit` and `max_score` change only in COMPARE and on reset.

## Test plan

- **All-zero canvas:** any weights, start -> `done` at edge 7860, `predicted_digit`=0, `max_score`=0 (tie rule).
- **Single class preference:**
  - Stimulus: pixels 0..99 set; weight=+1 for class 7, 0 for all others.
  - Response: `predicted_digit`=7, `max_score`=100.
- **Tie and negatives:**
  - Classes 3 and 5 both score +50 -> digit 3.
  - All weights = -1 except class 9 = 0 on set pixels -> digit 9, `max_score`=0.
  - All-negative case: 10 pixels set, class c weight = -(10-c) -> digit 9, `max_score`=-10.
- **Enable gating:**
  - Stimulus: drop `en` for 100 cycles during class 4 RUN.
  - Response: `done` at edge 7960; identical digit/score to the ungated run; `rd_en`=0 throughout the gap.
- **Reset mid-run and restart:**
  - Stimulus: assert reset at edge 3000.
  - Response: next cycle `busy`=0, `done`=0, `predicted_digit`=0.
  - Re-start gives the correct result at +7860.
- **Start in DONE:**
  - Stimulus: pulse `start` while `done`=1.
  - Response: no state change and outputs held; a fresh run requires reset first.
